// File: rtl/load_store_queue_if.sv
// Dispatch, ROB-head, RS snoop, data-cache and result-broadcast signals of the load/store queue.
// slave is the queue side; master is the surrounding pipeline and cache.
interface load_store_queue_if #(
    parameter int ROB_WIDTH_BIT = 4,
    parameter int OFFSET_WIDTH  = 12
) ();
    logic                     inst_valid;
    logic [3:0]               inst_type;
    logic [31:0]              inst_r1;
    logic [31:0]              inst_r2;
    logic                     inst_has_dep1;
    logic                     inst_has_dep2;
    logic [ROB_WIDTH_BIT-1:0] inst_dep1;
    logic [ROB_WIDTH_BIT-1:0] inst_dep2;
    logic [OFFSET_WIDTH-1:0]  inst_offset;
    logic [ROB_WIDTH_BIT-1:0] inst_rob_id;
    logic                     full;

    logic                     rob_head_valid;
    logic [ROB_WIDTH_BIT-1:0] rob_head_id;

    logic                     rs_ready;
    logic [ROB_WIDTH_BIT-1:0] rs_rob_id;
    logic [31:0]              rs_value;

    logic                     cache_valid;
    logic                     cache_wr;
    logic [2:0]               cache_size;
    logic [31:0]              cache_addr;
    logic [31:0]              cache_value;
    logic                     cache_ready;
    logic [31:0]              cache_res;

    logic                     lsb_ready;
    logic [ROB_WIDTH_BIT-1:0] lsb_rob_id;
    logic [31:0]              lsb_value;

    modport slave (
        input  inst_valid, inst_type, inst_r1, inst_r2, inst_has_dep1, inst_has_dep2,
               inst_dep1, inst_dep2, inst_offset, inst_rob_id,
               rob_head_valid, rob_head_id, rs_ready, rs_rob_id, rs_value,
               cache_ready, cache_res,
        output full, cache_valid, cache_wr, cache_size, cache_addr, cache_value,
               lsb_ready, lsb_rob_id, lsb_value
    );

    modport master (
        output inst_valid, inst_type, inst_r1, inst_r2, inst_has_dep1, inst_has_dep2,
               inst_dep1, inst_dep2, inst_offset, inst_rob_id,
               rob_head_valid, rob_head_id, rs_ready, rs_rob_id, rs_value,
               cache_ready, cache_res,
        input  full, cache_valid, cache_wr, cache_size, cache_addr, cache_value,
               lsb_ready, lsb_rob_id, lsb_value
    );
endinterface

// File: rtl/load_store_queue.sv
// In-order load/store queue between dispatch and the data cache, with operand wakeup and flush.
// Define LSQ_PERF_EN to add the perf_loads / perf_stores / perf_full_cycles counters.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | no request outstanding; head issues when eligible
//   ST_WAIT  | request on the cache bus, result reported on cache_ready
//   ST_DRAIN | flushed load still on the cache bus, result discarded
module load_store_queue #(
    parameter int LSQ_SIZE_BIT  = 3,
    parameter int ROB_WIDTH_BIT = 4,
    parameter int OFFSET_WIDTH  = 12
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic rdy_in,
    input  logic flush,
    load_store_queue_if.slave bus
`ifdef LSQ_PERF_EN
    ,
    output logic [31:0] perf_loads,
    output logic [31:0] perf_stores,
    output logic [31:0] perf_full_cycles
`endif
);
    localparam int SIZE = 1 << LSQ_SIZE_BIT;

    typedef logic [LSQ_SIZE_BIT-1:0]  ptr_t;
    typedef logic [LSQ_SIZE_BIT:0]    cnt_t;
    typedef logic [ROB_WIDTH_BIT-1:0] tag_t;

    // Stall one slot early: the decoder sees full a cycle late and may push once more.
    localparam cnt_t FULL_AT = cnt_t'(SIZE - 1);

    typedef struct packed {
        logic [3:0]              typ;
        logic [31:0]             r1;
        logic [31:0]             r2;
        logic                    has_dep1;
        logic                    has_dep2;
        tag_t                    dep1;
        tag_t                    dep2;
        logic [OFFSET_WIDTH-1:0] offset;
        tag_t                    rob_id;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    entry_t          ent_q [SIZE];
    entry_t          ent_d [SIZE];
    logic [SIZE-1:0] valid_q, valid_d;
    ptr_t            head_q, head_d;
    ptr_t            tail_q, tail_d;
    cnt_t            count_q, count_d;

    logic            cache_valid_q, cache_valid_d;
    logic            cache_wr_q, cache_wr_d;
    logic [2:0]      cache_size_q, cache_size_d;
    logic [31:0]     cache_addr_q, cache_addr_d;
    logic [31:0]     cache_value_q, cache_value_d;
    logic            infl_store_q, infl_store_d;
    tag_t            infl_rob_q, infl_rob_d;

    entry_t          head_ent;
    entry_t          push_ent;
    logic            head_elig;
    logic            lsb_ready;
    tag_t            lsb_rob_id;
    logic [31:0]     lsb_value;
    logic            pop;
    logic            push;

`ifdef LSQ_PERF_EN
    logic [31:0]     perf_loads_q, perf_loads_d;
    logic [31:0]     perf_stores_q, perf_stores_d;
    logic [31:0]     perf_full_q, perf_full_d;
`endif

    // RS result wins over the queue's own result when both carry the awaited tag.
    function automatic entry_t wake(entry_t e, logic rs_v, tag_t rs_tag, logic [31:0] rs_val,
                                    logic lb_v, tag_t lb_tag, logic [31:0] lb_val);
        entry_t r;
        r = e;
        if (e.has_dep1) begin
            if (rs_v && rs_tag == e.dep1) begin
                r.r1       = rs_val;
                r.has_dep1 = 1'b0;
            end else if (lb_v && lb_tag == e.dep1) begin
                r.r1       = lb_val;
                r.has_dep1 = 1'b0;
            end
        end
        if (e.has_dep2) begin
            if (rs_v && rs_tag == e.dep2) begin
                r.r2       = rs_val;
                r.has_dep2 = 1'b0;
            end else if (lb_v && lb_tag == e.dep2) begin
                r.r2       = lb_val;
                r.has_dep2 = 1'b0;
            end
        end
        return r;
    endfunction

    assign head_ent  = ent_q[head_q];
    assign head_elig = valid_q[head_q] && !head_ent.has_dep1 && !head_ent.has_dep2 &&
                       (!head_ent.typ[3] ||
                        (bus.rob_head_valid && bus.rob_head_id == head_ent.rob_id));

    // A committed store still reports through a flush; a flushed load never does.
    assign lsb_ready  = bus.cache_ready && (state_q == ST_WAIT) && (infl_store_q || !flush);
    assign lsb_rob_id = lsb_ready ? infl_rob_q : '0;
    assign lsb_value  = (lsb_ready && !infl_store_q) ? bus.cache_res : 32'd0;

    assign bus.full        = (count_q >= FULL_AT);
    assign bus.cache_valid = cache_valid_q;
    assign bus.cache_wr    = cache_wr_q;
    assign bus.cache_size  = cache_size_q;
    assign bus.cache_addr  = cache_addr_q;
    assign bus.cache_value = cache_value_q;
    assign bus.lsb_ready   = lsb_ready;
    assign bus.lsb_rob_id  = lsb_rob_id;
    assign bus.lsb_value   = lsb_value;

    always_comb begin
        push_ent.typ      = bus.inst_type;
        push_ent.r1       = bus.inst_r1;
        push_ent.r2       = bus.inst_r2;
        push_ent.has_dep1 = bus.inst_has_dep1;
        push_ent.has_dep2 = bus.inst_has_dep2;
        push_ent.dep1     = bus.inst_dep1;
        push_ent.dep2     = bus.inst_dep2;
        push_ent.offset   = bus.inst_offset;
        push_ent.rob_id   = bus.inst_rob_id;
        push_ent = wake(push_ent, bus.rs_ready, bus.rs_rob_id, bus.rs_value,
                        lsb_ready, lsb_rob_id, lsb_value);
    end

    always_comb begin
        state_d       = state_q;
        ent_d         = ent_q;
        valid_d       = valid_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        cache_valid_d = cache_valid_q;
        cache_wr_d    = cache_wr_q;
        cache_size_d  = cache_size_q;
        cache_addr_d  = cache_addr_q;
        cache_value_d = cache_value_q;
        infl_store_d  = infl_store_q;
        infl_rob_d    = infl_rob_q;
        pop           = 1'b0;
        push          = 1'b0;
`ifdef LSQ_PERF_EN
        perf_loads_d  = perf_loads_q;
        perf_stores_d = perf_stores_q;
        perf_full_d   = perf_full_q;
`endif

        if (rdy_in) begin
            for (int i = 0; i < SIZE; i++) begin
                if (valid_q[i]) begin
                    ent_d[i] = wake(ent_q[i], bus.rs_ready, bus.rs_rob_id, bus.rs_value,
                                    lsb_ready, lsb_rob_id, lsb_value);
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (head_elig && !flush) begin
                        cache_valid_d = 1'b1;
                        cache_wr_d    = head_ent.typ[3];
                        cache_size_d  = head_ent.typ[2:0];
                        cache_addr_d  = head_ent.r1 + 32'(signed'(head_ent.offset));
                        cache_value_d = head_ent.r2;
                        infl_store_d  = head_ent.typ[3];
                        infl_rob_d    = head_ent.rob_id;
                        pop           = 1'b1;
                        state_d       = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.cache_ready) begin
                        cache_valid_d = 1'b0;
                        state_d       = ST_IDLE;
                    end else if (flush && !infl_store_q) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (bus.cache_ready) begin
                        cache_valid_d = 1'b0;
                        state_d       = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            push = bus.inst_valid && !flush;

            if (pop) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + ptr_t'(1);
            end
            if (push) begin
                ent_d[tail_q]   = push_ent;
                valid_d[tail_q] = 1'b1;
                tail_d          = tail_q + ptr_t'(1);
            end
            if (push && !pop) begin
                count_d = count_q + cnt_t'(1);
            end else if (pop && !push) begin
                count_d = count_q - cnt_t'(1);
            end

            if (flush) begin
                valid_d = '0;
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end

`ifdef LSQ_PERF_EN
            if (pop && head_ent.typ[3]) perf_stores_d = perf_stores_q + 32'd1;
            if (pop && !head_ent.typ[3]) perf_loads_d = perf_loads_q + 32'd1;
            if (bus.full) perf_full_d = perf_full_q + 32'd1;
`endif
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= ST_IDLE;
            valid_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            cache_valid_q <= 1'b0;
            cache_wr_q    <= 1'b0;
            cache_size_q  <= '0;
            cache_addr_q  <= '0;
            cache_value_q <= '0;
            infl_store_q  <= 1'b0;
            infl_rob_q    <= '0;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            cache_valid_q <= cache_valid_d;
            cache_wr_q    <= cache_wr_d;
            cache_size_q  <= cache_size_d;
            cache_addr_q  <= cache_addr_d;
            cache_value_q <= cache_value_d;
            infl_store_q  <= infl_store_d;
            infl_rob_q    <= infl_rob_d;
        end
    end

    // Payload needs no reset; valid_q gates every use of it.
    always_ff @(posedge clk_in) begin
        ent_q <= ent_d;
    end

`ifdef LSQ_PERF_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            perf_loads_q  <= '0;
            perf_stores_q <= '0;
            perf_full_q   <= '0;
        end else begin
            perf_loads_q  <= perf_loads_d;
            perf_stores_q <= perf_stores_d;
            perf_full_q   <= perf_full_d;
        end
    end

    assign perf_loads       = perf_loads_q;
    assign perf_stores      = perf_stores_q;
    assign perf_full_cycles = perf_full_q;
`endif
endmodule

// File: doc/load_store_queue.md
Name: load_store_queue

Overview:
- Parametrised successor to the in-order load/store buffer.
- Sits between the Decoder/dispatch stage and the data cache, and snoops the reservation-station and own result buses.
- Adds a registered request stage, explicit IDLE/WAIT/DRAIN FSM, occupancy counter with one-slot dispatch slack, and pipeline flush on misprediction.
- Stores issue only when their ROB entry is at the ROB head.

Parameters:
LSQ_SIZE_BIT, 3, log2 of entry count (SIZE = 2^LSQ_SIZE_BIT, min 1)
ROB_WIDTH_BIT, 4, width of ROB tags
OFFSET_WIDTH, 12, immediate offset width, sign-extended to 32

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global enable; all state holds when low
inst_valid  in  1  dispatch strobe
inst_type  in  4  [3]=store, [2]=signed, [1:0]=0 byte/1 half/2 word
inst_r1, inst_r2  in  32  base / store data operands
inst_has_dep1, inst_has_dep2  in  1  operand pending
inst_dep1, inst_dep2  in  ROB_WIDTH_BIT  producer tags
inst_offset  in  OFFSET_WIDTH  address offset
inst_rob_id  in  ROB_WIDTH_BIT  tag of this op
full  out  1  dispatch stall
rob_head_valid  in  1  ROB non-empty
rob_head_id  in  ROB_WIDTH_BIT  tag at ROB head
flush  in  1  misprediction clear
rs_ready  in  1  RS result valid
rs_rob_id  in  ROB_WIDTH_BIT  RS result tag
rs_value  in  32  RS result value
cache_valid, cache_wr  out  1  request / write
cache_size  out  3  copy of inst_type[2:0]
cache_addr, cache_value  out  32  request address / store data
cache_ready  in  1  one-cycle completion pulse
cache_res  in  32  load data, valid with cache_ready
lsb_ready  out  1  result broadcast
lsb_rob_id  out  ROB_WIDTH_BIT  result tag
lsb_value  out  32  result (0 for stores)

Behaviour:
- Reset: head = tail = count = 0, all entries invalid, FSM = IDLE, all cache_* outputs 0, full = 0.
- Storage: circular queue of SIZE entries holding type, r1, r2, dep1/2, has_dep1/2, offset, rob_id. Head and tail wrap modulo SIZE.
- count: +1 on push, -1 on pop, unchanged when both occur.
- full = (count >= SIZE-1). Gives one cycle of slack for the registered decoder stall.
- Push on inst_valid: write the entry at tail.
  - An operand with has_dep set is captured in the same cycle if rs_ready or lsb_ready carries a matching tag; RS takes priority over LSB.
  - Otherwise has_dep stays set.
- Wakeup, every cycle, for each valid entry with has_depN: on a tag match on rs (priority) or lsb, latch the value and clear has_depN.
- Head eligible when all of the following hold:
  - the head entry is valid and both deps are clear;
  - the entry is a load, or (rob_head_valid and rob_head_id == entry.rob_id).
- FSM:
  - IDLE: if head eligible, register cache_addr = r1 + sext(offset), cache_value = r2, cache_wr = type[3], cache_size = type[2:0], cache_valid = 1. Pop head (head+1, count-1). Go to WAIT. cache_valid therefore rises the cycle after eligibility.
  - WAIT: hold all cache_* stable. On cache_ready: cache_valid = 0 next cycle, go to IDLE. There is one idle bubble before the next issue.
  - DRAIN: as WAIT, but results are suppressed.
- Result: lsb_ready = cache_ready and state == WAIT (combinational). lsb_rob_id is the latched tag; lsb_value = cache_res for loads, 0 for stores. Both outputs are 0 when lsb_ready = 0.
- Flush (priority over push and issue):
  - All entries are invalidated and head = tail = count = 0 next cycle.
  - An in-flight load (WAIT) moves to DRAIN.
  - An in-flight store completes normally in WAIT. It is already committed, so its lsb_ready is still emitted.
  - A flush during DRAIN stays in DRAIN.
  - cache_valid is never dropped before cache_ready.
- Simultaneous flush and cache_ready in WAIT: a load is suppressed (no lsb_ready); a store reports.
- rdy_in low: no state change. Combinational outputs still reflect held state.
- Reset mid-request returns the FSM to IDLE immediately. The cache shares reset, so no drain is needed.

Optional Feature:
- Macro: LSQ_PERF_EN.
- Defined: adds outputs perf_loads (32), perf_stores (32) and perf_full_cycles (32).
  - perf_loads / perf_stores increment on each issued load / store.
  - perf_full_cycles increments each rdy_in cycle with full = 1.
  - All counters reset to 0 and are not cleared by flush.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. Reset, then dispatch one load: r1=0x1000, offset=0xFFC, no deps. Expect cache_valid the next cycle with addr=0x0FFC, size per type, wr=0. Return cache_ready with res=0xDEADBEEF. Expect lsb_ready for one cycle with that value and tag.
2. Dispatch a store, rob_id=5, while rob_head_id=3. Expect no cache_valid. Set rob_head_id=5. Expect cache_valid=1, wr=1 the next cycle, and lsb_value=0 on completion.
3. Load with has_dep1, dep1=7. Pulse rs_ready, rs_rob_id=7, rs_value=0x2000 in the same cycle as dispatch. Expect a captured operand and issue with addr=0x2000+offset.
4. Fill the queue with SIZE=8 blocked stores. Expect full=1 at count=7 and no overflow. Release the head; expect full to drop once count falls below 7.
5. Load in WAIT, assert flush. Expect count=0 next cycle, cache_valid held, then cache_ready gives lsb_ready=0. The next dispatched entry lands at index 0.
6. Back-to-back loads via tail wrap (indices 7 then 0). Expect in-order issue with one-cycle bubbles. With LSQ_PERF_EN, expect perf_loads=2.
